// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
//
// Time-shares one 4-digit seven-segment display controller among four
// requesters: sources 0..2 take turns round-robin, source 3 is an alert source
// that preempts them. The current owner's digit codes and decimal points are
// forwarded (registered) to the display controller for a fixed dwell period.
//
// Parameters
//   SIMULATE : 0 -> dwell of 100_000_000 cycles (1 s at 100 MHz)
//              1 -> dwell of 8 cycles (simulation)
//
// Ports
//   clk            in   1   system clock (100 MHz)
//   reset          in   1   synchronous, active-low reset
//   req            in   4   per-source request, bit 3 = alert source
//   src_d          in  80   source i digits at [20i+19:20i] = {d3,d2,d1,d0}
//   src_dp         in  16   source i decimal points at [4i+3:4i]
//   d0..d3         out  5   digit codes to the display controller (23 = blank)
//   dp             out  4   decimal points to the display controller
//   grant          out  4   one-hot current owner, 0 when idle
//   done           out  4   one-cycle pulse when source i completes a dwell
// -----------------------------------------------------------------------------
module display_scheduler #(
    parameter int SIMULATE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [79:0] src_d,
    input  logic [15:0] src_dp,
    output logic [4:0]  d0,
    output logic [4:0]  d1,
    output logic [4:0]  d2,
    output logic [4:0]  d3,
    output logic [3:0]  dp,
    output logic [3:0]  grant,
    output logic [3:0]  done
);

    // Last counter value of a dwell; the counter starts at 0 on each grant.
    localparam logic [26:0] DWELL_LAST = (SIMULATE != 0) ? 27'd7 : 27'd99_999_999;
    localparam logic [4:0]  BLANK      = 5'd23;
    localparam logic [1:0]  ALERT      = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_SHOW
    } state_t;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [1:0]  r_owner;
    logic [1:0]  r_ptr;     // last low-priority source that finished or withdrew
    logic [26:0] r_count;
    logic [3:0]  r_grant;
    logic [3:0]  r_done;
    logic [19:0] r_digits;  // {d3,d2,d1,d0}
    logic [3:0]  r_dp;

    // -------------------------------------------------------------------------
    // Next-owner decision
    // -------------------------------------------------------------------------
    logic        w_keep;        // current owner continues its dwell
    logic [1:0]  w_ptr_next;
    logic [3:0]  w_done_next;
    logic [1:0]  w_cand0;
    logic [1:0]  w_cand1;
    logic [1:0]  w_cand2;
    logic        w_arb_valid;
    logic [1:0]  w_arb_idx;
    logic        w_next_valid;
    logic [1:0]  w_next_idx;
    logic [19:0] w_next_digits;
    logic [3:0]  w_next_dp;

    // Successor of a low-priority source index in the 0 -> 1 -> 2 -> 0 ring.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Events on the current owner. Withdrawal is tested first so that a source
    // dropping its request on the last dwell cycle gets no done pulse. A dwell
    // end ahead of preemption lets the owner collect its done while the alert
    // source is granted on the same edge.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        w_keep      = 1'b0;
        w_ptr_next  = r_ptr;
        w_done_next = '0;
        if (r_state == ST_SHOW) begin
            if (!req[r_owner]) begin
                if (r_owner != ALERT) begin
                    w_ptr_next = r_owner;
                end
            end else if (r_count == DWELL_LAST) begin
                w_done_next[r_owner] = 1'b1;
                if (r_owner != ALERT) begin
                    w_ptr_next = r_owner;
                end
            end else begin
                // A preempted low source keeps ptr, so it is not charged a turn.
                w_keep = !(req[3] && (r_owner != ALERT));
            end
        end
    end

    // Search order starts after the (possibly just updated) pointer, so the
    // source that just finished is considered last.
    assign w_cand0 = rr_next(w_ptr_next);
    assign w_cand1 = rr_next(w_cand0);
    assign w_cand2 = rr_next(w_cand1);

    always_comb begin
        w_arb_valid = 1'b1;
        w_arb_idx   = ALERT;
        if (req[3]) begin
            w_arb_idx = ALERT;
        end else if (req[w_cand0]) begin
            w_arb_idx = w_cand0;
        end else if (req[w_cand1]) begin
            w_arb_idx = w_cand1;
        end else if (req[w_cand2]) begin
            w_arb_idx = w_cand2;
        end else begin
            w_arb_valid = 1'b0;
        end
    end

    assign w_next_valid = w_keep | w_arb_valid;
    assign w_next_idx   = w_keep ? r_owner : w_arb_idx;

    // Live data of the next owner; reloaded every cycle so source updates
    // propagate while the grant is held.
    always_comb begin
        w_next_digits = src_d[19:0];
        w_next_dp     = src_dp[3:0];
        case (w_next_idx)
            2'd0: begin
                w_next_digits = src_d[19:0];
                w_next_dp     = src_dp[3:0];
            end
            2'd1: begin
                w_next_digits = src_d[39:20];
                w_next_dp     = src_dp[7:4];
            end
            2'd2: begin
                w_next_digits = src_d[59:40];
                w_next_dp     = src_dp[11:8];
            end
            default: begin
                w_next_digits = src_d[79:60];
                w_next_dp     = src_dp[15:12];
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: reset is sampled on the clock edge (synchronous), and all state is
    // written with non-blocking assignments so every register sees the values
    // from before the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= 2'd0;
            r_ptr    <= 2'd2;
            r_count  <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_digits <= {4{BLANK}};
            r_dp     <= '0;
        end else begin
            r_ptr  <= w_ptr_next;
            r_done <= w_done_next;
            if (w_next_valid) begin
                r_state  <= ST_SHOW;
                r_owner  <= w_next_idx;
                r_grant  <= 4'b0001 << w_next_idx;
                r_digits <= w_next_digits;
                r_dp     <= w_next_dp;
                r_count  <= w_keep ? r_count + 27'd1 : '0;
            end else begin
                r_state  <= ST_IDLE;
                r_owner  <= 2'd0;
                r_grant  <= '0;
                r_digits <= {4{BLANK}};
                r_dp     <= '0;
                r_count  <= '0;
            end
        end
    end

    assign d0    = r_digits[4:0];
    assign d1    = r_digits[9:5];
    assign d2    = r_digits[14:10];
    assign d3    = r_digits[19:15];
    assign dp    = r_dp;
    assign grant = r_grant;
    assign done  = r_done;

endmodule

// File: tb/tb_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_scheduler
//
// Self-checking bench for display_scheduler (SIMULATE=1, dwell of 8 cycles).
// A behavioural model tracks owner / dwell count / round-robin pointer from
// the scheduling rules and is compared against the DUT on every falling edge.
// Directed scenarios add literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_display_scheduler;

    localparam int DWELL = 8;
    localparam logic [4:0] BLANK = 5'd23;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [79:0] src_d = '0;
    logic [15:0] src_dp = '0;
    logic [4:0]  d0, d1, d2, d3;
    logic [3:0]  dp, grant, done;

    int n_total = 0;
    int n_bad   = 0;
    bit cmp_en  = 1'b0;

    display_scheduler #(.SIMULATE(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .src_d  (src_d),
        .src_dp (src_dp),
        .d0     (d0),
        .d1     (d1),
        .d2     (d2),
        .d3     (d3),
        .dp     (dp),
        .grant  (grant),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    // Advance one clock; inputs are changed and literals checked 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    int          m_owner  = -1;   // -1 means idle
    int          m_cnt    = 0;    // cycles already spent in the current dwell
    int          m_ptr    = 2;
    logic [3:0]  m_done   = '0;
    logic [19:0] m_digits = {4{BLANK}};
    logic [3:0]  m_dp     = '0;

    function automatic int pick(input logic [3:0] r, input int p);
        if (r[3]) return 3;
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (p + k) % 3;
            if (r[c[1:0]]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        bit handover;
        int o;
        m_done = '0;
        if (!reset) begin
            m_owner = -1;
            m_cnt   = 0;
            m_ptr   = 2;
        end else begin
            handover = 1'b1;
            o = m_owner;
            if (o >= 0) begin
                if (!req[o[1:0]]) begin
                    if (o < 3) m_ptr = o;
                end else if (m_cnt == DWELL - 1) begin
                    m_done[o[1:0]] = 1'b1;
                    if (o < 3) m_ptr = o;
                end else if (!(req[3] && o < 3)) begin
                    handover = 1'b0;
                    m_cnt++;
                end
            end
            if (handover) begin
                m_owner = pick(req, m_ptr);
                m_cnt   = 0;
            end
        end
        if (m_owner < 0) begin
            m_digits = {4{BLANK}};
            m_dp     = '0;
        end else begin
            m_digits = src_d[20*m_owner +: 20];
            m_dp     = src_dp[4*m_owner +: 4];
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("grant", grant, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("done", done, m_done);
            check("digits", {d3, d2, d1, d0}, m_digits);
            check("dp", dp, m_dp);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic [3:0] rr_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};

    initial begin
        // Source i digit j = 4i+j; decimal points src0=3, src1=C, src2=5, src3=A.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                src_d[20*i + 5*j +: 5] = 5'(4*i + j);
        src_dp = 16'hA5C3;

        // Reset held with every source requesting.
        reset = 1'b0;
        req   = 4'hF;
        step();
        cmp_en = 1'b1;
        repeat (2) step();
        check("rst_grant", grant, 4'b0000);
        check("rst_done", done, 4'b0000);
        check("rst_d0", d0, BLANK);
        check("rst_d3", d3, BLANK);
        check("rst_dp", dp, 4'h0);

        // Round robin among 0..2.
        reset = 1'b1;
        req   = 4'b0111;
        for (int r = 0; r < 4; r++) begin
            step();
            check("rr_grant", grant, rr_exp[r]);
            check("rr_done", done, (r == 0) ? 4'b0000 : rr_exp[r-1]);
            check("rr_d0", d0, 5'(4 * (r % 3)));
            repeat (7) step();
            check("rr_hold", grant, rr_exp[r]);
        end

        // Preemption of source 1 after 3 cycles.
        step();
        check("pre_g1", grant, 4'b0010);
        check("pre_done0", done, 4'b0001);
        repeat (2) step();
        req = 4'b1111;
        step();
        check("pre_grant3", grant, 4'b1000);
        check("pre_nodone", done, 4'b0000);
        check("pre_d0", d0, 5'd12);
        check("pre_dp", dp, 4'hA);
        repeat (8) step();
        check("pre_done3a", done, 4'b1000);
        check("pre_hold3", grant, 4'b1000);
        repeat (8) step();
        check("pre_done3b", done, 4'b1000);
        repeat (3) step();
        req = 4'b0011;
        step();
        check("pre_back1", grant, 4'b0010);
        check("pre_back_done", done, 4'b0000);

        // Withdrawal: source 0 alone, dropped at dwell cycle 4.
        req = 4'b0001;
        step();
        check("wd_grant0", grant, 4'b0001);
        repeat (4) step();
        req = 4'b0000;
        step();
        check("wd_idle", grant, 4'b0000);
        check("wd_nodone", done, 4'b0000);
        check("wd_blank", d2, BLANK);
        check("wd_dp", dp, 4'h0);

        // Live update of source 2 data while granted.
        src_d[59:40] = {5'd1, 5'd2, 5'd3, 5'd4};
        req = 4'b0100;
        step();
        check("live_grant", grant, 4'b0100);
        check("live_old", d0, 5'd4);
        step();
        src_d[59:40] = {5'hA, 5'hB, 5'hC, 5'hD};
        check("live_still_old", d0, 5'd4);
        step();
        check("live_new_d0", d0, 5'hD);
        check("live_new_d3", d3, 5'hA);
        check("live_keep", grant, 4'b0100);

        // Reset during SHOW at count 5, then restart.
        repeat (3) step();
        reset = 1'b0;
        step();
        check("mrst_grant", grant, 4'b0000);
        check("mrst_d1", d1, BLANK);
        check("mrst_done", done, 4'b0000);
        reset = 1'b1;
        req   = 4'b0111;
        step();
        check("mrst_first", grant, 4'b0001);
        check("mrst_d0", d0, 5'd0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            step();
            reset = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 5) == 0)
                req[2:0] = 3'($urandom);
            if (req[3]) begin
                if ($urandom_range(0, 11) == 0) req[3] = 1'b0;
            end else begin
                if ($urandom_range(0, 39) == 0) req[3] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                src_d  = {16'($urandom), $urandom, $urandom};
                src_dp = 16'($urandom);
            end
        end

        step();
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
